// File: rtl/nebula_trap_ctrl_if.sv
// Trap sequencer bus: commit-stage requests, CSR inputs, pipeline and fetch handshakes.
interface nebula_trap_ctrl_if #(
   parameter int XLEN = 64
);
   logic            exc_valid;
   logic [4:0]      exc_code;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic [XLEN-1:0] irq_pc;
   logic [XLEN-1:0] mip;
   logic [XLEN-1:0] mie_en;
   logic            mstatus_mie;
   logic            mret_valid;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;
   logic            flush;
   logic            drain_ack;
   logic            trap;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_pc;
   logic [XLEN-1:0] trap_value;
   logic            mret_strobe;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            redirect_ready;
   logic            busy;

   // core/CSR side: raises requests, consumes strobes and redirects
   modport master (
      output exc_valid, exc_code, exc_pc, exc_tval, irq_pc, mip, mie_en, mstatus_mie,
             mret_valid, mtvec, mepc, drain_ack, redirect_ready,
      input  flush, trap, trap_cause, trap_pc, trap_value, mret_strobe,
             redirect_valid, redirect_pc, busy
   );

   // trap controller side
   modport slave (
      input  exc_valid, exc_code, exc_pc, exc_tval, irq_pc, mip, mie_en, mstatus_mie,
             mret_valid, mtvec, mepc, drain_ack, redirect_ready,
      output flush, trap, trap_cause, trap_pc, trap_value, mret_strobe,
             redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/nebula_trap_ctrl.sv
// Trap sequencer: arbitrates exceptions / machine interrupts / MRET, drains the
// pipeline, strobes the CSR file and redirects fetch.
//
// state    | meaning
// IDLE     | arbitrating requests each cycle
// DRAIN    | flush asserted, waiting for drain_ack
// COMMIT   | one-cycle trap strobe to the CSR file
// REDIRECT | redirect_valid held until fetch accepts
module nebula_trap_ctrl #(
   parameter int XLEN    = 64,
   parameter int HART_ID = 0
) (
   input logic             clk,
   input logic             rst,
   nebula_trap_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

   state_t          state, state_nxt;
   logic            kind_mret;
   logic            lat_irq;
   logic [XLEN-1:0] lat_cause, lat_pc, lat_value;
   logic [XLEN-1:0] cause_q, pc_q, value_q, redirect_pc_q;
   logic            mret_strobe_q;
   logic            irq_mei, irq_msi, irq_mti, irq_hit;
   logic [4:0]      irq_code;
   logic [XLEN-1:0] vec_base, vec_target;

   assign irq_mei = bus.mip[11] & bus.mie_en[11] & bus.mstatus_mie;
   assign irq_msi = bus.mip[3]  & bus.mie_en[3]  & bus.mstatus_mie;
   assign irq_mti = bus.mip[7]  & bus.mie_en[7]  & bus.mstatus_mie;
   assign irq_hit = irq_mei | irq_msi | irq_mti;

   // fixed interrupt priority MEI > MSI > MTI
   always_comb begin
      irq_code = 5'd0;
      if (irq_mei)      irq_code = 5'd11;
      else if (irq_msi) irq_code = 5'd3;
      else if (irq_mti) irq_code = 5'd7;
   end

   // handler address; vectored offset is code*4, the cause MSB drops out of the shift
   assign vec_base   = {bus.mtvec[XLEN-1:2], 2'b00};
   assign vec_target = (bus.mtvec[1:0] == 2'b01 && lat_irq)
                     ? vec_base + {lat_cause[XLEN-3:0], 2'b00} : vec_base;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.exc_valid || irq_hit || bus.mret_valid) state_nxt = DRAIN;
         DRAIN:    if (bus.drain_ack) state_nxt = kind_mret ? REDIRECT : COMMIT;
         COMMIT:   state_nxt = REDIRECT;
         REDIRECT: if (bus.redirect_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // request latches, CSR-facing trap registers, redirect target and MRET strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         kind_mret     <= 1'b0;
         lat_irq       <= 1'b0;
         lat_cause     <= '0;
         lat_pc        <= '0;
         lat_value     <= '0;
         cause_q       <= '0;
         pc_q          <= '0;
         value_q       <= '0;
         redirect_pc_q <= '0;
         mret_strobe_q <= 1'b0;
      end else begin
         mret_strobe_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.exc_valid) begin
                  kind_mret <= 1'b0;
                  lat_irq   <= 1'b0;
                  lat_cause <= XLEN'(bus.exc_code);
                  lat_pc    <= bus.exc_pc;
                  lat_value <= bus.exc_tval;
               end else if (irq_hit) begin
                  kind_mret <= 1'b0;
                  lat_irq   <= 1'b1;
                  lat_cause <= {1'b1, (XLEN-1)'(irq_code)};
                  lat_pc    <= bus.irq_pc;
                  lat_value <= '0;
               end else if (bus.mret_valid) begin
                  kind_mret <= 1'b1;
               end
            end
            DRAIN: begin
               if (bus.drain_ack) begin
                  if (kind_mret) begin
                     redirect_pc_q <= bus.mepc;
                     mret_strobe_q <= 1'b1;
                  end else begin
                     cause_q <= lat_cause;
                     pc_q    <= lat_pc;
                     value_q <= lat_value;
                  end
               end
            end
            COMMIT:  redirect_pc_q <= vec_target;
            default: ;
         endcase
      end
   end

   // Moore outputs
   always_comb begin
      bus.flush          = (state == DRAIN);
      bus.trap           = (state == COMMIT);
      bus.redirect_valid = (state == REDIRECT);
      bus.busy           = (state != IDLE);
      bus.mret_strobe    = mret_strobe_q;
      bus.trap_cause     = cause_q;
      bus.trap_pc        = pc_q;
      bus.trap_value     = value_q;
      bus.redirect_pc    = redirect_pc_q;
   end

   // strobe exclusivity
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.trap && bus.mret_strobe))
            else $error("hart %0d: trap and mret_strobe together", HART_ID);
         assert (!(bus.flush && bus.redirect_valid))
            else $error("hart %0d: flush and redirect_valid together", HART_ID);
      end
   end
endmodule

// File: tb/tb_nebula_trap_ctrl.sv
// Self-checking bench: directed scenarios plus randomized transactions against
// a transaction-level prediction of cause / pc / value / fetch target.
module tb_nebula_trap_ctrl;
   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;
   logic [63:0] last_cause = '0, last_pc = '0, last_value = '0;

   nebula_trap_ctrl_if #(.XLEN(XLEN)) tif ();

   nebula_trap_ctrl #(.XLEN(XLEN), .HART_ID(0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      tif.exc_valid  = 1'b0;
      tif.mret_valid = 1'b0;
      tif.mip        = '0;
      tif.exc_code   = '0;
      tif.exc_pc     = '0;
      tif.exc_tval   = '0;
   endtask

   // requests while busy must be ignored
   task automatic drive_noise();
      tif.exc_valid  = 1'($urandom_range(0, 1));
      tif.mret_valid = 1'($urandom_range(0, 1));
      tif.mip        = 64'($urandom) | 64'h888;
      tif.exc_code   = 5'($urandom);
      tif.exc_pc     = {$urandom, $urandom};
   endtask

   task automatic run_txn(input string tag, input bit exc, input logic [4:0] code,
                          input logic [63:0] epc, input logic [63:0] tval, input logic [63:0] ipc,
                          input logic [63:0] mip_v, input logic [63:0] mie_v, input bit gmie,
                          input bit mret, input logic [63:0] mtvec_v, input logic [63:0] mepc_v,
                          input int d_dly, input int r_dly);
      int          kind;
      bit          is_irq;
      logic [63:0] en, e_cause, e_pc, e_val, e_tgt, icode;
      kind = 0; is_irq = 0; e_cause = '0; e_pc = '0; e_val = '0; icode = '0;
      en = mip_v & mie_v & {64{gmie}};
      if (exc) begin
         kind = 1; e_cause = 64'(code); e_pc = epc; e_val = tval;
      end else if (en[11] || en[3] || en[7]) begin
         kind = 1; is_irq = 1;
         icode = en[11] ? 64'd11 : en[3] ? 64'd3 : 64'd7;
         e_cause = (64'd1 << 63) | icode; e_pc = ipc; e_val = '0;
      end else if (mret) begin
         kind = 2;
      end
      if (kind == 2)                             e_tgt = mepc_v;
      else if (is_irq && mtvec_v[1:0] == 2'b01)  e_tgt = (mtvec_v & ~64'd3) + icode * 4;
      else                                       e_tgt = mtvec_v & ~64'd3;

      @(posedge clk); #1;
      tif.exc_valid = exc; tif.exc_code = code; tif.exc_pc = epc; tif.exc_tval = tval;
      tif.irq_pc = ipc; tif.mip = mip_v; tif.mie_en = mie_v; tif.mstatus_mie = gmie;
      tif.mret_valid = mret; tif.mtvec = mtvec_v; tif.mepc = mepc_v;
      tif.drain_ack = 1'b0; tif.redirect_ready = 1'b0;
      @(posedge clk); #1;
      if (kind == 0) begin
         idle_inputs();
         @(negedge clk);
         chk({tag, ".idle_busy"}, 64'(tif.busy), 64'd0);
         chk({tag, ".idle_flush"}, 64'(tif.flush), 64'd0);
         return;
      end
      for (int i = 1; i <= d_dly; i++) begin
         drive_noise();
         tif.drain_ack = (i == d_dly);
         @(negedge clk);
         chk({tag, ".flush"}, {62'd0, tif.flush, tif.busy}, 64'd3);
         chk({tag, ".drain_quiet"}, {61'd0, tif.trap, tif.redirect_valid, tif.mret_strobe}, 64'd0);
         @(posedge clk); #1;
      end
      tif.drain_ack = 1'b0;
      if (kind == 1) begin
         drive_noise();
         @(negedge clk);
         chk({tag, ".trap"}, {61'd0, tif.trap, tif.flush, tif.mret_strobe}, 64'd4);
         chk({tag, ".cause"}, tif.trap_cause, e_cause);
         chk({tag, ".tpc"}, tif.trap_pc, e_pc);
         chk({tag, ".tval"}, tif.trap_value, e_val);
         last_cause = e_cause; last_pc = e_pc; last_value = e_val;
         @(posedge clk); #1;
      end
      for (int i = 1; i <= r_dly; i++) begin
         drive_noise();
         tif.redirect_ready = (i == r_dly);
         @(negedge clk);
         chk({tag, ".rvalid"}, {62'd0, tif.redirect_valid, tif.trap}, 64'd2);
         chk({tag, ".rpc"}, tif.redirect_pc, e_tgt);
         chk({tag, ".mret_strobe"}, 64'(tif.mret_strobe), 64'((kind == 2) && (i == 1)));
         @(posedge clk); #1;
      end
      tif.redirect_ready = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk({tag, ".done_busy"}, {62'd0, tif.busy, tif.redirect_valid}, 64'd0);
      chk({tag, ".hold_cause"}, tif.trap_cause, last_cause);
      chk({tag, ".hold_pc"}, tif.trap_pc, last_pc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      tif.irq_pc = '0; tif.mie_en = '0; tif.mstatus_mie = 1'b0;
      tif.mtvec = '0; tif.mepc = '0; tif.drain_ack = 1'b0; tif.redirect_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst.ctrl", {59'd0, tif.busy, tif.flush, tif.trap, tif.redirect_valid, tif.mret_strobe}, 64'd0);
      chk("rst.cause", tif.trap_cause, 64'd0);
      chk("rst.rpc", tif.redirect_pc, 64'd0);

      run_txn("illegal", 1, 5'd2, 64'h8000_0010, 64'hDEAD, 64'h0, 64'h0, 64'h0, 0, 0,
              64'h1000_0000, 64'h0, 1, 1);
      run_txn("vec_irq", 0, 5'd0, 64'h0, 64'h0, 64'h8000_0100, 64'h880, 64'h880, 1, 0,
              64'h1000_0001, 64'h0, 1, 1);
      run_txn("masked", 0, 5'd0, 64'h0, 64'h0, 64'h8000_0100, 64'h888, 64'h888, 0, 0,
              64'h1000_0001, 64'h0, 1, 1);
      run_txn("mti", 0, 5'd0, 64'h0, 64'h0, 64'h8000_0180, 64'h888, 64'h080, 1, 0,
              64'h1000_0000, 64'h0, 2, 2);
      run_txn("mret", 0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 1,
              64'h1000_0000, 64'h8000_0200, 5, 2);
      run_txn("simul", 1, 5'd3, 64'h8000_0300, 64'h55, 64'h8000_0400, 64'h8, 64'h8, 1, 1,
              64'h2000_0001, 64'h8000_0200, 2, 3);
      run_txn("irq_vs_mret", 0, 5'd0, 64'h0, 64'h0, 64'h8000_0500, 64'h8, 64'h8, 1, 1,
              64'h2000_0001, 64'h8000_0200, 1, 1);
      run_txn("vec_wrap", 0, 5'd0, 64'h0, 64'h0, 64'h8000_0600, 64'h800, 64'h800, 1, 0,
              64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 1, 1);

      // reset while waiting in REDIRECT
      @(posedge clk); #1;
      tif.exc_valid = 1'b1; tif.exc_code = 5'd5; tif.exc_pc = 64'h8000_0700;
      tif.exc_tval = 64'h77; tif.mtvec = 64'h3000_0000; tif.drain_ack = 1'b1;
      @(posedge clk); #1 idle_inputs();
      @(posedge clk); #1 tif.drain_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid.in_redirect", 64'(tif.redirect_valid), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstmid.ctrl", {59'd0, tif.busy, tif.flush, tif.trap, tif.redirect_valid, tif.mret_strobe}, 64'd0);
      chk("rstmid.rpc", tif.redirect_pc, 64'd0);
      chk("rstmid.cause", tif.trap_cause, 64'd0);
      chk("rstmid.value", tif.trap_value, 64'd0);
      last_cause = '0; last_pc = '0; last_value = '0;
      run_txn("post_rst", 1, 5'd13, 64'h8000_0800, 64'h1234, 64'h0, 64'h0, 64'h0, 0, 0,
              64'h3000_0001, 64'h0, 1, 1);

      for (int t = 0; t < 40; t++) begin
         logic [63:0] mv, me, tv;
         bit          ex, gm, mr;
         ex = ($urandom_range(0, 3) == 0);
         gm = 1'($urandom_range(0, 1));
         mr = 1'($urandom_range(0, 1));
         mv = {$urandom, $urandom} & ($urandom_range(0, 1) ? 64'hFFFF_FFFF_FFFF_F777 : 64'hFFFF);
         me = {$urandom, $urandom};
         tv = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
         run_txn($sformatf("rnd%0d", t), ex, 5'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, mv, me, gm, mr,
                 tv, {$urandom, $urandom}, $urandom_range(1, 4), $urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
